uart_cmd_sequencer: RTL and testbench
=====================================

Name: uart_cmd_sequencer

Overview:
Sequences the UART link between the byte-level UART core and the LED channel register file. It parses fixed 3-byte command frames (cmd, channel, value), writes brightness registers or returns register readback, and drives the active-low CTS flow-control line. An inter-byte timeout resynchronises the parser after idle gaps. It sits inside Top, between the UART RX/TX cores and the LED PWM register bank.

Parameters:
NUM_CH, 5, number of LED channels (valid channel indices 0..NUM_CH-1)
CH_W, 3, width of the channel index toward the register file
TIMEOUT_CYC, 240, idle clk cycles inside a partial frame before the frame is discarded (about 4 byte times at 2 Mbaud / 84 ns clk)

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
tx_valid  out  1  reply byte available for the UART TX core
tx_data  out  8  reply byte
tx_ready  in  1  TX core accepts tx_data when tx_valid && tx_ready
uart_cts  out  1  active-low clear-to-send: 0 = host may send
wr_en  out  1  one-cycle register write strobe
wr_ch  out  CH_W  write channel index
wr_val  out  8  write brightness value
rd_ch  out  CH_W  read channel index (combinational read)
rd_val  in  8  register file data for rd_ch, same cycle
frame_done  out  1  one-cycle pulse per completed frame, valid or not
err_cnt  out  8  saturating count of bad frames, timeouts and dropped bytes

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: tx_valid=0, tx_data=0, uart_cts=1, wr_en=0, wr_ch=0, wr_val=0, rd_ch=0, frame_done=0, err_cnt=0, state=IDLE, timer=0.
- uart_cts is a registered output. It is 0 in IDLE, GOT_CMD and GOT_CH, and 1 in EXEC and REPLY.
- States:
  - IDLE: on rx_valid, latch cmd and go to GOT_CMD.
  - GOT_CMD: on rx_valid, latch ch and go to GOT_CH.
  - GOT_CH: on rx_valid, latch val and go to EXEC.
  - EXEC: lasts exactly one cycle, drives rd_ch=ch, and pulses frame_done. Actions by frame:
    - cmd=0x00 (SET) and ch<NUM_CH: wr_en=1 with wr_ch/wr_val, then go to IDLE. No reply.
    - cmd=0x01 (GET) and ch<NUM_CH: tx_data=rd_val, then go to REPLY. The val byte is ignored.
    - Any other cmd, or ch>=NUM_CH: tx_data=0x15 (NAK), err_cnt+1, then go to REPLY.
  - REPLY: tx_valid=1 with tx_data held stable until tx_ready. On the handshake cycle, tx_valid goes to 0 next cycle and the state returns to IDLE.
- Latency: third byte strobe at cycle N -> wr_en at N+1. For replies, tx_valid rises at N+2.
- Timer:
  - Clears on every accepted byte and counts only in GOT_CMD and GOT_CH.
  - When the timer reaches TIMEOUT_CYC-1 with no rx_valid: discard the partial frame, go to IDLE, err_cnt+1. No frame_done, no reply.
  - If rx_valid arrives on the expiry cycle, the byte wins: it is accepted and the timer clears.
- rx_valid in EXEC or REPLY (host ignored CTS): the byte is dropped, err_cnt+1, and the state is unaffected.
- err_cnt saturates at 0xFF. When two error events fall in the same cycle (NAK plus dropped byte), it increments by 1 only.
- rst asserted mid-frame or mid-reply: all state returns to reset values on the next edge. A pending reply is abandoned and tx_valid drops; no partial write occurs.
- Width rules:
  - ch is compared against NUM_CH as a full 8-bit value before truncation to CH_W.
  - wr_ch and rd_ch are ch[CH_W-1:0].

Decomposition:
- Shared package rtl_pkg:
  - CMD_SET=8'h00, CMD_GET=8'h01, NAK_BYTE=8'h15
  - sequencer state enum (IDLE, GOT_CMD, GOT_CH, EXEC, REPLY)
  - BYTE_W=8
- Sub-module rtl_idle_timer: counter with clear/enable inputs and an expiry-pulse output, parameterised by TIMEOUT_CYC. Everything else lives in the top FSM.

Test Plan:
1. After rst, send bytes 0x00,0x01,0x02 with tx_ready=1 -> one wr_en pulse with wr_ch=1, wr_val=0x02; frame_done pulses once; no tx_valid; err_cnt=0; uart_cts=0 again 2 cycles after the third byte.
2. With rd_val modelled from register 3 = 0xA5, send 0x01,0x03,0x00; hold tx_ready=0 for 10 cycles -> tx_valid=1 with tx_data=0xA5 stable for 10 cycles, uart_cts=1 throughout; raise tx_ready -> tx_valid=0 next cycle, back to IDLE.
3. Send 0x00,0x07,0x10 (ch>=NUM_CH) -> no wr_en, tx_data=0x15, err_cnt=1. Then send cmd 0x42 with channel 0 -> NAK, err_cnt=2.
4. Send 0x00,0x01, then idle 1000 cycles, then 0x00,0x01,0x02 -> timeout gives err_cnt=1; the next frame writes ch1=0x02 exactly once, with no misaligned write.
5. While in REPLY with tx_ready=0, inject rx_valid byte 0x55 -> byte dropped, err_cnt increments, reply still 0xA5. Assert rst for one cycle mid-REPLY -> tx_valid=0, uart_cts=1 in reset, then 0; err_cnt=0.
6. Issue 300 NAK frames -> err_cnt saturates at 0xFF and does not wrap.

Source files
------------

// File: rtl/uart_cmd_sequencer_pkg.sv
// Shared constants and state type for the UART command sequencer.
// Frames are three bytes: command, channel, value.
package uart_cmd_sequencer_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CMD_SET  = 8'h00;
  localparam logic [BYTE_W-1:0] CMD_GET  = 8'h01;
  localparam logic [BYTE_W-1:0] NAK_BYTE = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GOT_CMD,
    GOT_CH,
    EXEC,
    REPLY
  } seq_state_t;

endpackage

// File: rtl/uart_cmd_sequencer_idle_timer.sv
// Inter-byte idle counter: counts enabled cycles and pulses expire on the
// cycle the count reaches TIMEOUT_CYC-1 without a clear.
module uart_cmd_sequencer_idle_timer #(
  parameter int TIMEOUT_CYC = 240
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // A clear in the same cycle (byte accepted) always beats expiry.
  assign expire = en && !clr && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Parses 3-byte UART command frames, writes LED brightness registers or
// returns readback / NAK bytes, and drives the active-low CTS line.
module uart_cmd_sequencer
  import uart_cmd_sequencer_pkg::*;
#(
  parameter int NUM_CH      = 5,
  parameter int CH_W        = 3,
  parameter int TIMEOUT_CYC = 240
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              tx_valid,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic              uart_cts,
  output logic              wr_en,
  output logic [CH_W-1:0]   wr_ch,
  output logic [BYTE_W-1:0] wr_val,
  output logic [CH_W-1:0]   rd_ch,
  input  logic [BYTE_W-1:0] rd_val,
  output logic              frame_done,
  output logic [BYTE_W-1:0] err_cnt
);

  localparam logic [BYTE_W-1:0] NUM_CH_B = BYTE_W'(NUM_CH);

  seq_state_t        state;
  logic [BYTE_W-1:0] cmd;
  logic [BYTE_W-1:0] ch;
  logic              timer_en;
  logic              timer_clr;
  logic              timeout;
  logic              busy;
  logic              ch_ok;
  logic              frame_bad;
  logic              err_ev;

  assign timer_en  = (state == GOT_CMD) || (state == GOT_CH);
  assign timer_clr = rx_valid || !timer_en;

  uart_cmd_sequencer_idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_idle_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .en    (timer_en),
    .expire(timeout)
  );

  // Channel range is judged on the full byte so e.g. 8'h0B never aliases ch 3.
  assign busy      = (state == EXEC) || (state == REPLY);
  assign ch_ok     = ch < NUM_CH_B;
  assign frame_bad = !ch_ok || ((cmd != CMD_SET) && (cmd != CMD_GET));

  // Coincident error sources (NAK plus dropped byte) count once.
  assign err_ev = timeout || (busy && rx_valid) || ((state == EXEC) && frame_bad);

  // TX handshake: tx_valid/tx_data stay put until a cycle with tx_valid && tx_ready;
  // tx_valid falls on the following cycle and the byte is never re-offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd        <= '0;
      ch         <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      uart_cts   <= 1'b1;
      wr_en      <= 1'b0;
      wr_ch      <= '0;
      wr_val     <= '0;
      rd_ch      <= '0;
      frame_done <= 1'b0;
      err_cnt    <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      uart_cts   <= 1'b0;
      if (err_ev && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      case (state)
        IDLE: begin
          if (rx_valid) begin
            cmd   <= rx_data;
            state <= GOT_CMD;
          end
        end
        GOT_CMD: begin
          if (rx_valid) begin
            ch    <= rx_data;
            wr_ch <= rx_data[CH_W-1:0];
            rd_ch <= rx_data[CH_W-1:0];
            state <= GOT_CH;
          end else if (timeout) begin
            state <= IDLE;
          end
        end
        GOT_CH: begin
          if (rx_valid) begin
            wr_val     <= rx_data;
            wr_en      <= (cmd == CMD_SET) && ch_ok;
            frame_done <= 1'b1;
            uart_cts   <= 1'b1;
            state      <= EXEC;
          end else if (timeout) begin
            state <= IDLE;
          end
        end
        EXEC: begin
          if (!frame_bad && (cmd == CMD_SET)) begin
            state <= IDLE;
          end else begin
            tx_data  <= frame_bad ? NAK_BYTE : rd_val;
            tx_valid <= 1'b1;
            uart_cts <= 1'b1;
            state    <= REPLY;
          end
        end
        REPLY: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end else begin
            uart_cts <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Bench for uart_cmd_sequencer: frame-level reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_uart_cmd_sequencer;

  localparam int NUM_CH      = 5;
  localparam int CH_W        = 3;
  localparam int TIMEOUT_CYC = 240;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            tx_ready = 1'b1;
  logic            tx_valid;
  logic [7:0]      tx_data;
  logic            uart_cts;
  logic            wr_en;
  logic [CH_W-1:0] wr_ch;
  logic [7:0]      wr_val;
  logic [CH_W-1:0] rd_ch;
  logic [7:0]      rd_val;
  logic            frame_done;
  logic [7:0]      err_cnt;

  always #5 clk = ~clk;

  uart_cmd_sequencer #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .uart_cts(uart_cts), .wr_en(wr_en), .wr_ch(wr_ch), .wr_val(wr_val),
    .rd_ch(rd_ch), .rd_val(rd_val), .frame_done(frame_done), .err_cnt(err_cnt)
  );

  // Register file the DUT talks to.
  logic [7:0] hw_regs [8] = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
  always @(posedge clk) if (wr_en) hw_regs[wr_ch] <= wr_val;
  assign rd_val = hw_regs[rd_ch];

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: bytes collect in a queue; a full queue is one frame.
  logic [7:0] m_frame[$];
  logic [7:0] m_regs [8] = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
  int         m_gap = 0;
  bit         m_exec = 1'b0;
  bit         m_reply = 1'b0;
  logic       e_tx_valid = 1'b0, e_cts = 1'b1, e_wr_en = 1'b0, e_fd = 1'b0;
  logic [7:0] e_tx_data = 8'h00, e_wr_val = 8'h00, e_err = 8'h00;
  logic [2:0] e_wr_ch = 3'd0, e_rd_ch = 3'd0;

  task automatic model_step();
    bit err_ev;
    logic [7:0] c, chb;
    if (rst) begin
      m_frame.delete();
      m_gap = 0; m_exec = 1'b0; m_reply = 1'b0;
      e_tx_valid = 1'b0; e_tx_data = 8'h00; e_cts = 1'b1; e_wr_en = 1'b0;
      e_wr_ch = 3'd0; e_wr_val = 8'h00; e_rd_ch = 3'd0; e_fd = 1'b0; e_err = 8'h00;
      return;
    end
    err_ev = 1'b0;
    e_wr_en = 1'b0;
    e_fd = 1'b0;
    if (m_exec) begin
      m_exec = 1'b0;
      c = m_frame[0];
      chb = m_frame[1];
      if (rx_valid) err_ev = 1'b1;
      if (chb < NUM_CH && c == 8'h00) begin
        m_regs[chb] = m_frame[2];
      end else if (chb < NUM_CH && c == 8'h01) begin
        m_reply = 1'b1;
        e_tx_data = m_regs[chb];
      end else begin
        m_reply = 1'b1;
        e_tx_data = 8'h15;
        err_ev = 1'b1;
      end
      m_frame.delete();
      e_tx_valid = m_reply;
    end else if (m_reply) begin
      if (rx_valid) err_ev = 1'b1;
      if (tx_ready) begin
        m_reply = 1'b0;
        e_tx_valid = 1'b0;
      end
    end else if (rx_valid) begin
      m_frame.push_back(rx_data);
      m_gap = 0;
      if (m_frame.size() == 3) begin
        c = m_frame[0];
        chb = m_frame[1];
        m_exec = 1'b1;
        e_fd = 1'b1;
        e_rd_ch = chb[2:0];
        e_wr_ch = chb[2:0];
        e_wr_val = m_frame[2];
        e_wr_en = (c == 8'h00) && (chb < NUM_CH);
      end
    end else if (m_frame.size() != 0) begin
      if (m_gap == TIMEOUT_CYC - 1) begin
        m_frame.delete();
        m_gap = 0;
        err_ev = 1'b1;
      end else begin
        m_gap++;
      end
    end
    if (err_ev && e_err != 8'hFF) e_err = e_err + 8'd1;
    e_cts = m_exec || m_reply;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      cmp("tx_valid", 8'(tx_valid), 8'(e_tx_valid));
      cmp("uart_cts", 8'(uart_cts), 8'(e_cts));
      cmp("wr_en", 8'(wr_en), 8'(e_wr_en));
      cmp("frame_done", 8'(frame_done), 8'(e_fd));
      cmp("err_cnt", err_cnt, e_err);
      if (e_tx_valid) cmp("tx_data", tx_data, e_tx_data);
      if (e_wr_en) begin
        cmp("wr_ch", 8'(wr_ch), 8'(e_wr_ch));
        cmp("wr_val", wr_val, e_wr_val);
      end
      if (m_exec) cmp("rd_ch", 8'(rd_ch), 8'(e_rd_ch));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] chb, input logic [7:0] v);
    send_byte(c);
    send_byte(chb);
    send_byte(v);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_exec || m_reply || m_frame.size() != 0) && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    repeat (3) step();
    cmp("rst_tx_valid", 8'(tx_valid), 8'h00);
    cmp("rst_tx_data", tx_data, 8'h00);
    cmp("rst_cts", 8'(uart_cts), 8'h01);
    cmp("rst_wr_en", 8'(wr_en), 8'h00);
    cmp("rst_wr_ch", 8'(wr_ch), 8'h00);
    cmp("rst_wr_val", wr_val, 8'h00);
    cmp("rst_rd_ch", 8'(rd_ch), 8'h00);
    cmp("rst_frame_done", 8'(frame_done), 8'h00);
    cmp("rst_err_cnt", err_cnt, 8'h00);
    rst = 1'b0;
    chk_en = 1'b1;

    // SET ch1 = 0x02
    send_frame(8'h00, 8'h01, 8'h02);
    cmp("t1_wr_en", 8'(wr_en), 8'h01);
    cmp("t1_wr_ch", 8'(wr_ch), 8'h01);
    cmp("t1_wr_val", wr_val, 8'h02);
    cmp("t1_cts_exec", 8'(uart_cts), 8'h01);
    step();
    cmp("t1_cts_idle", 8'(uart_cts), 8'h00);
    cmp("t1_reg1", hw_regs[1], 8'h02);
    cmp("t1_err", err_cnt, 8'h00);

    // GET ch3 with back-pressure
    tx_ready = 1'b0;
    send_frame(8'h01, 8'h03, 8'h00);
    step();
    for (int i = 0; i < 10; i++) begin
      cmp("t2_tx_valid", 8'(tx_valid), 8'h01);
      cmp("t2_tx_data", tx_data, 8'hA5);
      cmp("t2_cts", 8'(uart_cts), 8'h01);
      step();
    end
    tx_ready = 1'b1;
    step();
    cmp("t2_tx_valid_drop", 8'(tx_valid), 8'h00);
    cmp("t2_cts_idle", 8'(uart_cts), 8'h00);

    // out-of-range channel, then unknown command
    send_frame(8'h00, 8'h07, 8'h10);
    step();
    cmp("t3_nak_data", tx_data, 8'h15);
    wait_idle();
    cmp("t3_err1", err_cnt, 8'h01);
    send_frame(8'h42, 8'h00, 8'h00);
    wait_idle();
    cmp("t3_err2", err_cnt, 8'h02);

    // timeout resynchronisation
    send_frame(8'h00, 8'h01, 8'h00);
    wait_idle();
    do_reset();
    send_byte(8'h00);
    send_byte(8'h01);
    idle(1000);
    cmp("t4_err_timeout", err_cnt, 8'h01);
    send_frame(8'h00, 8'h01, 8'h02);
    wait_idle();
    step();
    cmp("t4_reg1", hw_regs[1], 8'h02);
    cmp("t4_err", err_cnt, 8'h01);

    // expiry boundary: byte on the expiry cycle wins, one cycle later loses
    do_reset();
    send_byte(8'h00);
    send_byte(8'h02);
    idle(TIMEOUT_CYC - 1);
    send_byte(8'h33);
    wait_idle();
    step();
    cmp("tb_reg2_late_byte", hw_regs[2], 8'h33);
    cmp("tb_err_none", err_cnt, 8'h00);
    send_byte(8'h00);
    idle(TIMEOUT_CYC);
    cmp("tb_err_expired", err_cnt, 8'h01);
    send_frame(8'h00, 8'h02, 8'h44);
    wait_idle();
    step();
    cmp("tb_reg2_resync", hw_regs[2], 8'h44);

    // dropped byte during reply, then reset mid-reply
    do_reset();
    tx_ready = 1'b0;
    send_frame(8'h01, 8'h03, 8'h00);
    step();
    send_byte(8'h55);
    cmp("t5_err_drop", err_cnt, 8'h01);
    cmp("t5_tx_valid", 8'(tx_valid), 8'h01);
    cmp("t5_tx_data", tx_data, 8'hA5);
    rst = 1'b1;
    step();
    cmp("t5_rst_tx_valid", 8'(tx_valid), 8'h00);
    cmp("t5_rst_cts", 8'(uart_cts), 8'h01);
    cmp("t5_rst_err", err_cnt, 8'h00);
    rst = 1'b0;
    step();
    cmp("t5_cts_after", 8'(uart_cts), 8'h00);
    tx_ready = 1'b1;

    // saturation
    do_reset();
    repeat (300) begin
      send_frame(8'h42, 8'h00, 8'h00);
      wait_idle();
    end
    cmp("t6_err_sat", err_cnt, 8'hFF);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        tx_ready = 1'b1;
        idle($urandom_range(TIMEOUT_CYC - 10, TIMEOUT_CYC + 10));
      end
      rst = ($urandom_range(0, 499) == 0);
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(0, 6));
      tx_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    wait_idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
